// File: rtl/pix_mac_pkg.sv
// Shared types and helpers for the pixel MAC accumulator datapath.
package pix_mac_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } pix_tag_t;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StAccum = 1'b1
  } pix_state_e;

endpackage

// File: rtl/pix_add_tree.sv
// Registered lane-sum: sign-extends LANES signed inputs to OUT_W and sums them in one stage.
module pix_add_tree #(
  parameter int unsigned LANES = 4,
  parameter int unsigned IN_W  = 17,
  parameter int unsigned OUT_W = 22
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic [LANES*IN_W-1:0]  data_i,
  output logic [OUT_W-1:0]       sum_o
);

  logic [OUT_W-1:0] sum_d, sum_q;

  // Written as a flat reduction; synthesis balances it into a tree.
  always_comb begin
    sum_d = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_d = sum_d + OUT_W'($signed(data_i[l*IN_W +: IN_W]));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/pix_mac_accum.sv
// LANES-wide multiply, lane-sum and windowed accumulate with valid/ready backpressure.
module pix_mac_accum
  import pix_mac_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = 8,
  parameter int unsigned LANES       = 4,
  parameter int unsigned ACC_LEN_MAX = 9,
  localparam int unsigned ACC_WIDTH  = 2 * BIT_WIDTH + clog2(LANES) + clog2(ACC_LEN_MAX),
  localparam int unsigned LEN_W      = clog2(ACC_LEN_MAX + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [LANES*BIT_WIDTH-1:0] i_pix_weight,
  input  logic [LANES*BIT_WIDTH-1:0] i_pix_feature,
  input  logic [LANES-1:0]           i_lane_en,
  input  logic                       i_signed,
  input  logic [LEN_W-1:0]           i_acc_len,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_flush,
  output logic [ACC_WIDTH-1:0]       o_pix_feature,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_start,
  output logic                       o_busy
);

  // One extra bit holds both the unsigned and the signed product range.
  localparam int unsigned PROD_W = 2 * BIT_WIDTH + 1;

  function automatic logic [PROD_W-1:0] lane_mul(input logic [BIT_WIDTH-1:0] w,
                                                 input logic [BIT_WIDTH-1:0] f,
                                                 input logic             sgn);
    logic signed [2*BIT_WIDTH+1:0] we, fe, p;
    we = {{(BIT_WIDTH + 2){sgn & w[BIT_WIDTH-1]}}, w};
    fe = {{(BIT_WIDTH + 2){sgn & f[BIT_WIDTH-1]}}, f};
    p  = we * fe;
    return p[PROD_W-1:0];
  endfunction

  pix_state_e           state_q, state_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d, len_q, len_d, len_in;
  logic                 sgn_q, sgn_d, eff_sgn;
  logic                 start_q, start_d;
  logic                 stall, accept, adv;
  pix_tag_t             tag_in, s1_q, s2_q, s3_q;
  logic [LANES*PROD_W-1:0] prod_d, s1_prod_q;
  logic [ACC_WIDTH-1:0] tree_sum, acc_q, out_pix_q, out_pix_d;
  logic                 out_vld_q, out_vld_d;

  assign stall   = out_vld_q & ~i_ready;
  assign o_ready = ~stall;
  assign accept  = i_valid & ~stall & ~i_flush;
  assign adv     = ~stall & ~i_flush;
  assign eff_sgn = (state_q == StIdle) ? i_signed : sgn_q;

  always_comb begin
    len_in = i_acc_len;
    if (i_acc_len == '0) begin
      len_in = LEN_W'(1);
    end else if (i_acc_len > LEN_W'(ACC_LEN_MAX)) begin
      len_in = LEN_W'(ACC_LEN_MAX);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sgn_d   = sgn_q;
    start_d = 1'b0;
    tag_in  = '0;
    if (accept) begin
      tag_in.valid = 1'b1;
      unique case (state_q)
        StIdle: begin
          len_d        = len_in;
          sgn_d        = i_signed;
          start_d      = 1'b1;
          tag_in.first = 1'b1;
          if (len_in == LEN_W'(1)) begin
            tag_in.last = 1'b1;
          end else begin
            cnt_d   = LEN_W'(1);
            state_d = StAccum;
          end
        end
        StAccum: begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            tag_in.last = 1'b1;
            cnt_d       = '0;
            state_d     = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (i_flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_comb begin
    prod_d = '0;
    for (int l = 0; l < LANES; l++) begin
      if (i_lane_en[l]) begin
        prod_d[l*PROD_W +: PROD_W] = lane_mul(i_pix_weight[l*BIT_WIDTH +: BIT_WIDTH],
                                              i_pix_feature[l*BIT_WIDTH +: BIT_WIDTH],
                                              eff_sgn);
      end
    end
  end

  // A finished window moves to the output register as the previous result is taken.
  always_comb begin
    out_vld_d = out_vld_q;
    out_pix_d = out_pix_q;
    if (out_vld_q && i_ready) out_vld_d = 1'b0;
    if (adv && s3_q.valid && s3_q.last) begin
      out_vld_d = 1'b1;
      out_pix_d = acc_q;
    end
  end

  pix_add_tree #(
    .LANES (LANES),
    .IN_W  (PROD_W),
    .OUT_W (ACC_WIDTH)
  ) u_add_tree (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .en_i   (~stall),
    .data_i (s1_prod_q),
    .sum_o  (tree_sum)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_q     <= LEN_W'(1);
      sgn_q     <= 1'b0;
      start_q   <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      s1_prod_q <= '0;
      acc_q     <= '0;
      out_vld_q <= 1'b0;
      out_pix_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      sgn_q     <= sgn_d;
      start_q   <= start_d;
      out_vld_q <= out_vld_d;
      out_pix_q <= out_pix_d;
      if (i_flush) begin
        s1_q <= '0;
        s2_q <= '0;
        s3_q <= '0;
      end else if (!stall) begin
        s1_q <= tag_in;
        s2_q <= s1_q;
        s3_q <= s2_q;
      end
      if (!stall) s1_prod_q <= prod_d;
      if (adv && s2_q.valid) acc_q <= s2_q.first ? tree_sum : acc_q + tree_sum;
    end
  end

  assign o_pix_feature = out_pix_q;
  assign o_valid       = out_vld_q;
  assign o_start       = start_q;
  assign o_busy        = (state_q == StAccum) | s1_q.valid | s2_q.valid | s3_q.valid;

endmodule

// File: tb/tb_pix_mac_accum.sv
// Self-checking bench for pix_mac_accum: directed scenarios plus randomized traffic vs a window model.
module tb_pix_mac_accum;

  localparam int ACC_W = 22;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_pix_weight = '0, i_pix_feature = '0;
  logic [3:0]  i_lane_en = '0;
  logic        i_signed = 1'b0;
  logic [3:0]  i_acc_len = '0;
  logic        i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b1;
  logic        o_ready, o_valid, o_start, o_busy;
  logic [ACC_W-1:0] o_pix;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;

  // Reference model state: one open window, expected and observed result queues.
  bit     m_open = 0, m_sgn = 0;
  int     m_len = 0, m_cnt = 0;
  longint m_sum = 0;
  longint exp_q[$];
  longint got_q[$];

  pix_mac_accum #(
    .BIT_WIDTH   (8),
    .LANES       (4),
    .ACC_LEN_MAX (9)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_pix_weight  (i_pix_weight),
    .i_pix_feature (i_pix_feature),
    .i_lane_en     (i_lane_en),
    .i_signed      (i_signed),
    .i_acc_len     (i_acc_len),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_flush       (i_flush),
    .o_pix_feature (o_pix),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_start       (o_start),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap(input longint v);
    return v & ((longint'(1) << ACC_W) - 1);
  endfunction

  function automatic int clamp_len(input logic [3:0] l);
    if (l == 0) return 1;
    if (l > 9) return 9;
    return int'(l);
  endfunction

  function automatic longint beat_sum(input logic [31:0] w, input logic [31:0] f,
                                      input logic [3:0] en, input bit sgn);
    longint s, a, b;
    s = 0;
    for (int l = 0; l < 4; l++) begin
      if (en[l]) begin
        a = sgn ? longint'($signed(w[l*8 +: 8])) : longint'(w[l*8 +: 8]);
        b = sgn ? longint'($signed(f[l*8 +: 8])) : longint'(f[l*8 +: 8]);
        s += a * b;
      end
    end
    return s;
  endfunction

  // Monitor: samples mid-cycle, models windows and scores every taken result.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_open = 0;
      exp_q.delete();
    end else begin
      check("ready_rule", o_ready, !(o_valid && !i_ready));
      if (o_valid && i_ready) begin
        got_q.push_back(longint'(o_pix));
        check("result_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("result", o_pix, exp_q.pop_front());
      end
      if (i_valid && o_ready && !i_flush) begin
        if (!m_open) begin
          m_open = 1;
          m_len  = clamp_len(i_acc_len);
          m_sgn  = i_signed;
          m_cnt  = 0;
          m_sum  = 0;
        end
        m_sum += beat_sum(i_pix_weight, i_pix_feature, i_lane_en, m_sgn);
        m_cnt++;
        if (m_cnt == m_len) begin
          exp_q.push_back(wrap(m_sum));
          m_open = 0;
        end
      end
      if (i_flush) m_open = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns just after the edge that accepts it.
  task automatic beat(input logic [31:0] w, input logic [31:0] f, input logic [3:0] en,
                      input logic sgn, input logic [3:0] len);
    int t;
    t = 0;
    i_pix_weight = w; i_pix_feature = f; i_lane_en = en; i_signed = sgn; i_acc_len = len;
    i_valid = 1'b1;
    @(negedge clk);
    while (!o_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("accept_timeout", o_ready, 1);
    step();
  endtask

  task automatic drain();
    int t;
    t = 0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    while ((o_busy || o_valid) && t < 200) begin
      step();
      t++;
    end
    check("drain_timeout", t < 200, 1);
    check("model_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int t0;
    // Reset state.
    #12;
    check("rst_valid", o_valid, 0);
    check("rst_pix", o_pix, 0);
    check("rst_start", o_start, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ready", o_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: unsigned len=1, latency and start pulse.
    got_q.delete();
    beat(32'h02020202, 32'h06050403, 4'hF, 1'b0, 4'd1);
    i_valid = 1'b0;
    @(negedge clk);
    check("t1_start_pulse", o_start, 1);
    check("t1_valid_e1", o_valid, 0);
    check("t1_busy", o_busy, 1);
    @(negedge clk);
    check("t1_start_once", o_start, 0);
    check("t1_valid_e2", o_valid, 0);
    @(negedge clk);
    check("t1_valid_e3", o_valid, 0);
    @(negedge clk);
    check("t1_valid_e4", o_valid, 1);
    check("t1_value", o_pix, 36);
    step();
    drain();

    // 2: nine-beat windows, signed and unsigned extremes.
    got_q.delete();
    for (int b = 0; b < 9; b++) beat(32'h80808080, 32'h80808080, 4'hF, 1'b1, 4'd9);
    for (int b = 0; b < 9; b++) beat(32'h80808080, 32'h80808080, 4'hF, 1'b0, 4'd9);
    for (int b = 0; b < 9; b++) beat(32'hFFFFFFFF, 32'h01010101, 4'hF, 1'b1, 4'd9);
    drain();
    check("t2_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("t2_signed_min", got_q[0], 589824);
      check("t2_unsigned", got_q[1], 589824);
      check("t2_signed_neg", got_q[2], wrap(-36));
    end

    // 3: lane masks.
    got_q.delete();
    beat(32'h01010101, 32'h281E140A, 4'b0101, 1'b0, 4'd1);
    beat(32'h01010101, 32'h281E140A, 4'b0000, 1'b0, 4'd1);
    drain();
    check("t3_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t3_mask_0101", got_q[0], 40);
      check("t3_mask_0000", got_q[1], 0);
    end

    // 4: backpressure with a pending result.
    got_q.delete();
    i_ready = 1'b0;
    for (int k = 1; k <= 4; k++) beat(32'h01010101, {4{8'(k)}}, 4'hF, 1'b0, 4'd1);
    i_pix_feature = {4{8'd5}};
    i_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t4_ready_low", o_ready, 0);
      check("t4_valid_held", o_valid, 1);
      check("t4_pix_stable", o_pix, 4);
    end
    step();
    i_ready = 1'b1;
    beat(32'h01010101, {4{8'd5}}, 4'hF, 1'b0, 4'd1);
    drain();
    check("t4_count", got_q.size(), 5);
    for (int k = 0; k < 5 && k < got_q.size(); k++) check("t4_order", got_q[k], 4 * (k + 1));

    // 5: flush mid-window, then a fresh window.
    got_q.delete();
    for (int b = 0; b < 3; b++) beat(32'h01010101, 32'h01010101, 4'hF, 1'b0, 4'd5);
    i_flush = 1'b1;
    i_valid = 1'b1;
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    check("t5_busy_after_flush", o_busy, 0);
    step();
    beat(32'h01010101, 32'h01010101, 4'hF, 1'b0, 4'd2);
    beat(32'h01010101, 32'h01010101, 4'hF, 1'b0, 4'd2);
    drain();
    check("t5_count", got_q.size(), 1);
    if (got_q.size() == 1) check("t5_value", got_q[0], 8);

    // 5b: async reset mid-window.
    got_q.delete();
    for (int b = 0; b < 3; b++) beat(32'h01010101, 32'h01010101, 4'hF, 1'b0, 4'd5);
    i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #2;
    check("t5r_valid", o_valid, 0);
    check("t5r_pix", o_pix, 0);
    check("t5r_busy", o_busy, 0);
    check("t5r_ready", o_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    beat(32'h01010101, 32'h01010101, 4'hF, 1'b0, 4'd2);
    beat(32'h01010101, 32'h01010101, 4'hF, 1'b0, 4'd2);
    drain();
    check("t5r_count", got_q.size(), 1);
    if (got_q.size() == 1) check("t5r_value", got_q[0], 8);

    // 6: back-to-back windows, mode toggled mid-window, length 0 and 12.
    got_q.delete();
    t0 = cyc;
    beat(32'hFFFFFFFF, 32'h01010101, 4'hF, 1'b0, 4'd2);
    beat(32'hFFFFFFFF, 32'h01010101, 4'hF, 1'b1, 4'd5);
    beat(32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 1'b1, 4'd2);
    beat(32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 1'b0, 4'd2);
    beat(32'hFFFFFFFF, 32'h01010101, 4'hF, 1'b1, 4'd0);
    for (int b = 0; b < 9; b++) beat(32'h01010101, 32'h02020202, 4'hF, 1'(b), 4'd12);
    beat(32'h01010101, 32'h01010101, 4'hF, 1'b0, 4'd1);
    check("t6_throughput", cyc - t0, 15);
    drain();
    check("t6_count", got_q.size(), 5);
    if (got_q.size() == 5) begin
      check("t6_mode_kept_uns", got_q[0], 2040);
      check("t6_mode_kept_sgn", got_q[1], 8);
      check("t6_len0", got_q[2], wrap(-4));
      check("t6_len12_clamp", got_q[3], 72);
      check("t6_after_clamp", got_q[4], 4);
    end

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      i_ready       = ($urandom_range(0, 3) != 0);
      i_valid       = ($urandom_range(0, 3) != 0);
      i_pix_weight  = $urandom;
      i_pix_feature = $urandom;
      i_lane_en     = 4'($urandom);
      i_signed      = 1'($urandom);
      i_acc_len     = 4'($urandom_range(0, 15));
      step();
    end
    i_ready = 1'b1;
    for (int c = 0; c < 20 && m_open; c++) beat($urandom, $urandom, 4'hF, 1'b0, 4'd1);
    check("rand_window_closed", m_open, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
